// File: rtl/ssd_pkg.sv
// Shared display-code constants and encoder state encoding; SSD_render uses the same codes.
package ssd_pkg;

  localparam logic [3:0]  SSD_CODE_NEG   = 4'hA;
  localparam logic [3:0]  SSD_CODE_BLANK = 4'hB;
  localparam int unsigned SSD_DIGITS     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FMT  = 2'd2
  } ssd_state_e;

endpackage

// File: rtl/ssd_dabble_step.sv
// Combinational double-dabble correction: add 3 to every BCD nibble that is >= 5.
module ssd_dabble_step
  import ssd_pkg::*;
(
  input  logic [4*SSD_DIGITS-1:0] bcd_i,
  output logic [4*SSD_DIGITS-1:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    for (int i = 0; i < int'(SSD_DIGITS); i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/ssd_value_encoder.sv
// Signed binary to 4-nibble display code encoder (iterative double-dabble, one shift per clock).
// Build option: SSD_LEADING_ZERO_BLANK_EN blanks leading zeros and floats the minus sign.
module ssd_value_encoder
  import ssd_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_value,
  output logic [15:0]             digits,
  output logic                    out_valid,
  output logic                    overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  ssd_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic             sign_q;
  logic [WIDTH-1:0] mag_q;
  logic [15:0]      bcd_q;
  logic [15:0]      digits_q;
  logic             overflow_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] value_u;
  logic [WIDTH-1:0] mag_in;
  logic [15:0]      bcd_adj;
  logic [15:0]      fmt_digits;
  logic             fmt_ovf;

  assign value_u = in_value;
  // Two's-complement negate in WIDTH bits, so the most negative value yields 2^(WIDTH-1).
  assign mag_in  = value_u[WIDTH-1] ? (~value_u + {{(WIDTH-1){1'b0}}, 1'b1}) : value_u;

  ssd_dabble_step u_step (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic z3, z32, z321;
  assign z3   = (bcd_q[15:12] == 4'd0);
  assign z32  = z3 && (bcd_q[11:8] == 4'd0);
  assign z321 = z32 && (bcd_q[7:4] == 4'd0);
`endif

  always_comb begin
    fmt_ovf    = sign_q && (bcd_q[15:12] != 4'd0);
    fmt_digits = bcd_q;
    if (fmt_ovf) begin
      fmt_digits = {4{SSD_CODE_NEG}};
    end else begin
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (z3)   fmt_digits[15:12] = SSD_CODE_BLANK;
      if (z32)  fmt_digits[11:8]  = SSD_CODE_BLANK;
      if (z321) fmt_digits[7:4]   = SSD_CODE_BLANK;
      // Minus goes one nibble left of the most significant shown digit.
      if (sign_q) begin
        if (!z32)       fmt_digits[15:12] = SSD_CODE_NEG;
        else if (!z321) fmt_digits[11:8]  = SSD_CODE_NEG;
        else            fmt_digits[7:4]   = SSD_CODE_NEG;
      end
`else
      if (sign_q) fmt_digits[15:12] = SSD_CODE_NEG;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      digits_q    <= {4{SSD_CODE_BLANK}};
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q  <= value_u[WIDTH-1];
            mag_q   <= mag_in;
            bcd_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          bcd_q <= {bcd_adj[14:0], mag_q[WIDTH-1]};
          mag_q <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= ST_FMT;
        end
        ST_FMT: begin
          digits_q    <= fmt_digits;
          overflow_q  <= fmt_ovf;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign digits    = digits_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule
